// File: rtl/tmc4671_spi_responder.sv
// ---------------------------------------------------------------------------
// tmc4671_spi_responder
//
// SPI slave for the TMC4671 40-bit datagram link (write flag, 7-bit address,
// 32-bit data, MSB first). SCK/MOSI/nSCS are oversampled in the clk domain.
// Writes leave through a one-cycle register strobe. Reads request local data
// after the address byte and shift it out on MISO during the 32 data bits.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   SCK, MOSI     SPI clock and master data (MOSI sampled on SCK rise)
//   nSCS          active-low chip select
//   MISO          slave data, changes after SCK fall, 0 when not driving
//   MISO_oe       high while the synchronised select is low
//   reg_addr      address of the current/last frame
//   reg_wr_en     one-cycle write strobe, reg_wr_data is held afterwards
//   reg_rd_en     one-cycle read request, reg_rd_data sampled 1 clk later
//   frame_done    pulse on select release after a complete frame
//   frame_error   pulse on select release after a short frame
//   busy          high whenever the FSM is not idle
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a select falling edge
// ADDR     | receiving write flag + address (bits 39..32)
// FETCH    | capturing read data from the register port
// DATA     | receiving/sending the 32 data bits
// WAIT_CS  | frame complete, ignoring SCK until select is released
// ---------------------------------------------------------------------------
module tmc4671_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCK,
    input  logic        MOSI,
    input  logic        nSCS,
    output logic        MISO,
    output logic        MISO_oe,
    output logic [6:0]  reg_addr,
    output logic        reg_wr_en,
    output logic [31:0] reg_wr_data,
    output logic        reg_rd_en,
    input  logic [31:0] reg_rd_data,
    output logic        frame_done,
    output logic        frame_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_FETCH,
        ST_DATA,
        ST_WAIT_CS
    } state_t;

    // Reset values of the synchronisers can fake a select falling edge when
    // nSCS is already low at reset release; edges are masked until the
    // reset values have flushed through the chain.
    localparam logic [2:0] FLUSH_INIT = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   sck_d;
    logic                   ncs_d;
    logic [2:0]             flush_cnt;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [31:0] rx;
    logic [31:0] tx;
    logic        wr_flag;

    logic        sck_s;
    logic        mosi_s;
    logic        ncs_s;
    logic        selected;
    logic        sck_rise;
    logic        sck_fall;
    logic        ncs_fall;
    logic        ncs_rise;
    logic [31:0] rx_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '1;
            mosi_sync <= '0;
            ncs_sync  <= '1;
            sck_d     <= 1'b1;
            ncs_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nSCS};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ncs_s    = ncs_sync[SYNC_STAGES-1];
    assign selected = ~ncs_s;

    // SCK activity only counts while selected; this also drops an SCK edge
    // that coincides with the select release.
    assign sck_rise = selected & sck_s & ~sck_d;
    assign sck_fall = selected & ~sck_s & sck_d;
    assign ncs_fall = ~ncs_s & ncs_d & (flush_cnt == 3'd0);
    assign ncs_rise = ncs_s & ~ncs_d;

    assign rx_next  = {rx[30:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            flush_cnt   <= FLUSH_INIT;
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            wr_flag     <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (flush_cnt != 3'd0) begin
                flush_cnt <= flush_cnt - 3'd1;
            end

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (ncs_fall) begin
                        state <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (ncs_rise) begin
                        frame_error <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (reg_rd_en) begin
                        state <= ST_FETCH;
                    end else if (sck_rise) begin
                        rx      <= rx_next;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            reg_addr <= rx_next[6:0];
                            wr_flag  <= rx_next[7];
                            if (rx_next[7]) begin
                                tx    <= '0;
                                state <= ST_DATA;
                            end else begin
                                reg_rd_en <= 1'b1;
                            end
                        end
                    end
                end

                ST_FETCH: begin
                    if (ncs_rise) begin
                        frame_error <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tx    <= reg_rd_data;
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (ncs_rise) begin
                        frame_error <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sck_rise) begin
                        rx      <= rx_next;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd39) begin
                            state <= ST_WAIT_CS;
                        end
                    end else if (sck_fall && bit_cnt >= 6'd9) begin
                        // the fall between address and data bits keeps bit 31
                        tx <= {tx[30:0], 1'b0};
                    end
                end

                ST_WAIT_CS: begin
                    // bit_cnt == 40 marks the first cycle after the last bit
                    if (bit_cnt == 6'd40) begin
                        bit_cnt <= '0;
                        if (wr_flag) begin
                            reg_wr_en   <= 1'b1;
                            reg_wr_data <= rx;
                        end
                    end
                    if (ncs_rise) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign MISO    = selected & (state == ST_DATA) & tx[31];
    assign MISO_oe = selected;
    assign busy    = (state != ST_IDLE);

endmodule

// File: doc/tmc4671_spi_responder.md
Name: tmc4671_spi_responder

Overview:
- SPI slave that models the far end of the TMC4671 40-bit datagram link. Used as a bench/loopback target for the SPI master, and as a register port for an FPGA-side emulated controller.
- Oversamples SCK/MOSI/nSCS in the system clock domain and decodes each frame: bit 39 = write/notread, bits 38:32 = address, bits 31:0 = data, MSB first.
- Writes are issued on a local register-interface strobe. Reads fetch local data and shift it out on MISO during the 32 data bits.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on SCK, MOSI and nSCS before edge detection (legal range 2..3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- SCK  in  1  SPI clock from master; each high/low phase ≥ SYNC_STAGES+1 clk periods
- MOSI  in  1  master data, sampled on SCK rising edge
- nSCS  in  1  active-low chip select
- MISO  out  1  slave data, updated after SCK falling edge; 0 when not selected
- MISO_oe  out  1  high while nSCS (synchronised) is low
- reg_addr  out  7  address latched from the current frame
- reg_wr_en  out  1  one-cycle write strobe
- reg_wr_data  out  32  write data, valid while reg_wr_en is high, held afterwards
- reg_rd_en  out  1  one-cycle read request
- reg_rd_data  in  32  read data; must be valid exactly 1 clk after reg_rd_en
- frame_done  out  1  one-cycle pulse on nSCS rise after a complete 40-bit frame
- frame_error  out  1  one-cycle pulse on nSCS rise when fewer than 40 bits were received
- busy  out  1  high while in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, bit counter 0, shift registers 0, sync flops 1 for SCK/nSCS and 0 for MOSI.
- Synchronisation and edge detection: SCK, MOSI and nSCS pass through SYNC_STAGES flops. Edges are detected from the last stage against a one-cycle-delayed copy. MOSI is taken from the same stage as SCK.
- States: IDLE, ADDR, FETCH, DATA, WAIT_CS.
- IDLE:
  - Goes to ADDR only on a detected nSCS falling edge. A select that is already low at reset release is ignored until nSCS goes high again; this is the mid-frame reset behaviour.
  - Clears the bit counter.
- ADDR:
  - On each SCK rising edge, shift MOSI into rx[39:0] and increment the counter.
  - After the 8th bit, latch reg_addr = rx[6:0] and the write flag = rx[7].
  - Read: pulse reg_rd_en in the next cycle and go to FETCH.
  - Write: go directly to DATA.
  - MISO = 0 throughout ADDR.
- FETCH: one cycle. Load tx[31:0] from reg_rd_data, then go to DATA. MISO = tx[31] immediately, so bit 31 is stable before the 9th SCK rising edge.
- DATA:
  - On each SCK rising edge, sample MOSI.
  - On each SCK falling edge with 1..31 data bits already sampled, shift tx left by one (zero fill). MISO = tx[31].
  - The falling edge between the 8th and 9th rising edges does not shift.
  - On the 40th bit of a write frame, pulse reg_wr_en for 1 cycle with reg_wr_data = rx[31:0], then go to WAIT_CS.
  - On the 40th bit of a read frame, go to WAIT_CS with no strobe.
- WAIT_CS:
  - Further SCK edges are ignored and MISO is held at 0.
  - On nSCS rise, pulse frame_done and go to IDLE.
- Abort: nSCS rise in ADDR, FETCH or DATA pulses frame_error and returns to IDLE. No write strobe is issued; a reg_rd_en already issued is not retracted.
- Back-to-back frames: nSCS may fall again 1 clk after the frame_done cycle and must be accepted.
- Simultaneous events:
  - nSCS rise in the same cycle as the 40th SCK rising edge: the bit is discarded and the frame counts as aborted.
  - SCK edges while nSCS is high are ignored in every state.
- reg_addr and reg_wr_data hold their last values between frames.

Test Plan:
- Write frame 0x81_DEADBEEF at SCK phase 3 clk → one reg_wr_en pulse with reg_addr 0x01 and reg_wr_data 0xDEADBEEF; frame_done 1 pulse; frame_error 0; MISO 0 throughout.
- Read frame 0x05 + 32 dummy bits, reg_rd_data = 0x12345678 driven 1 clk after reg_rd_en → exactly one reg_rd_en; bits sampled by the master on rising edges 9..40 = 0x12345678; no reg_wr_en.
- Read with a 500 ns pause after the address byte, then repeat with no pause → both return identical data.
- Abort: nSCS high after 20 bits of a write → frame_error pulse, no reg_wr_en, busy low; next full write frame with 0x82_00000001 → writes 0x00000001 to 0x02.
- Extra clocks: 44 SCK pulses in one select → exactly one write, with data from bits 39..0 of the first 40; frame_done once.
- Reset asserted at bit 15 while nSCS stays low → outputs 0 and the rest of the frame is ignored; after nSCS rises, a new frame decodes correctly.
